// File: rtl/contador_bcd_ud_param.sv
// rtl/contador_bcd_ud_param.sv - parametrised packed-BCD up/down counter with range, preload and carry/borrow
//
// Optional build macro: CONTADOR_BCD_SAT_EN
//   undefined : wrap mode, MAX_VAL -> MIN_VAL raises carry, MIN_VAL -> MAX_VAL raises borrow
//   defined   : saturating mode, count sticks at the range ends, carry/borrow stay 0

module contador_bcd_ud_param #(
    parameter int NDIG    = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_up,
    input  logic              en_down,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_bcd,
    output logic [4*NDIG-1:0] digits,
    output logic              carry,
    output logic              borrow,
    output logic              load_err
);

    localparam int W = 4 * NDIG;

    // Decimal integer to packed BCD, evaluated only on constants at elaboration.
    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    logic         en_up_q;
    logic         en_down_q;
    logic         up_tick;
    logic         down_tick;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         nib_ok;
    logic         load_ok;
    logic         at_max;
    logic         at_min;
    logic [W-1:0] digits_nxt;
    logic         carry_nxt;
    logic         borrow_nxt;
    logic         load_err_nxt;

    // Rising-edge detect on the button levels; one tick per press.
    assign up_tick   = en_up & ~en_up_q;
    assign down_tick = en_down & ~en_down_q;

    assign at_max = (digits == MAX_BCD);
    assign at_min = (digits == MIN_BCD);

    // Per-digit BCD increment: a 9 rolls to 0 and carries into the next digit.
    always_comb begin
        logic c;
        inc_val = digits;
        c       = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                if (digits[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    c                 = 1'b0;
                end
            end
        end
    end

    // Per-digit BCD decrement: a 0 rolls to 9 and borrows from the next digit.
    always_comb begin
        logic b;
        dec_val = digits;
        b       = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (b) begin
                if (digits[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                    b                 = 1'b0;
                end
            end
        end
    end

    // Preload validity: every nibble a decimal digit, value inside the range.
    // With legal BCD nibbles the packed vector orders exactly like the decimal
    // value, so the range test is a plain vector compare. The leading 1 keeps
    // the lower-bound compare from degenerating to a constant when MIN_VAL is 0.
    always_comb begin
        nib_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                nib_ok = 1'b0;
            end
        end
        load_ok = nib_ok
                  && ({1'b1, load_bcd} >= {1'b1, MIN_BCD})
                  && (load_bcd <= MAX_BCD);
    end

    // Next count and pulses: load beats ticks, opposing ticks cancel.
    always_comb begin
        digits_nxt   = digits;
        carry_nxt    = 1'b0;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (load_ok) begin
                digits_nxt = load_bcd;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (up_tick && !down_tick) begin
            if (at_max) begin
`ifdef CONTADOR_BCD_SAT_EN
                digits_nxt = MAX_BCD;
`else
                digits_nxt = MIN_BCD;
                carry_nxt  = 1'b1;
`endif
            end else begin
                digits_nxt = inc_val;
            end
        end else if (down_tick && !up_tick) begin
            if (at_min) begin
`ifdef CONTADOR_BCD_SAT_EN
                digits_nxt = MIN_BCD;
`else
                digits_nxt = MAX_BCD;
                borrow_nxt = 1'b1;
`endif
            end else begin
                digits_nxt = dec_val;
            end
        end
    end

    // Edge-detect history runs through reset so a level held across release is not a tick.
    always_ff @(posedge clk) begin
        en_up_q   <= en_up;
        en_down_q <= en_down;
    end

    // Count and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits   <= MIN_BCD;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            digits   <= digits_nxt;
            carry    <= carry_nxt;
            borrow   <= borrow_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_contador_bcd_ud_param.sv
// tb/tb_contador_bcd_ud_param.sv - self-checking bench for contador_bcd_ud_param

module tb_contador_bcd_ud_param;

`ifdef CONTADOR_BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    // DUT0: defaults (00..59)
    logic       up0, dn0, ld0;
    logic [7:0] lb0, d0;
    logic       c0, b0, e0;
    // DUT1: 01..12
    logic       up1, dn1, ld1;
    logic [7:0] lb1, d1;
    logic       c1, b1, e1;
    // DUT2: 000..999
    logic        up2, dn2, ld2;
    logic [11:0] lb2, d2;
    logic        c2, b2, e2;

    always #5 clk = ~clk;

    contador_bcd_ud_param u_dut0 (
        .clk(clk), .reset(reset), .en_up(up0), .en_down(dn0), .load(ld0), .load_bcd(lb0),
        .digits(d0), .carry(c0), .borrow(b0), .load_err(e0)
    );

    contador_bcd_ud_param #(.NDIG(2), .MIN_VAL(1), .MAX_VAL(12)) u_dut1 (
        .clk(clk), .reset(reset), .en_up(up1), .en_down(dn1), .load(ld1), .load_bcd(lb1),
        .digits(d1), .carry(c1), .borrow(b1), .load_err(e1)
    );

    contador_bcd_ud_param #(.NDIG(3), .MIN_VAL(0), .MAX_VAL(999)) u_dut2 (
        .clk(clk), .reset(reset), .en_up(up2), .en_down(dn2), .load(ld2), .load_bcd(lb2),
        .digits(d2), .carry(c2), .borrow(b2), .load_err(e2)
    );

    typedef struct {
        int          id;
        logic [11:0] d;
        logic        c;
        logic        b;
        logic        e;
        string       name;
    } exp_t;

    typedef struct {
        logic       ld;
        logic [7:0] lb;
        logic       up;
        logic       dn;
        logic [7:0] d;
        logic       c;
        logic       b;
        logic       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] bcd8(input int v);
        logic [7:0] r;
        r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic push_exp(input int id, input logic [11:0] d, input logic c, input logic b,
                            input logic e, input string name);
        exp_t x;
        x.id = id; x.d = d; x.c = c; x.b = b; x.e = e; x.name = name;
        sb.push_back(x);
    endtask

    task automatic add(input logic ld, input logic [7:0] lb, input logic up, input logic dn,
                       input logic [7:0] d, input logic c, input logic b, input logic e);
        vec_t v;
        v.ld = ld; v.lb = lb; v.up = up; v.dn = dn; v.d = d; v.c = c; v.b = b; v.e = e;
        tbl.push_back(v);
    endtask

    // Advance one clock and retire every expectation queued for this edge.
    task automatic tick();
        exp_t        x;
        logic [11:0] ad;
        logic        ac, ab, ae;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.id)
                0:       begin ad = {4'h0, d0}; ac = c0; ab = b0; ae = e0; end
                1:       begin ad = {4'h0, d1}; ac = c1; ab = b1; ae = e1; end
                default: begin ad = d2;         ac = c2; ab = b2; ae = e2; end
            endcase
            n_cmp++;
            if (ad !== x.d || ac !== x.c || ab !== x.b || ae !== x.e) begin
                n_bad++;
                $display("FAIL %s: dut%0d got digits=%h carry=%b borrow=%b load_err=%b, want digits=%h carry=%b borrow=%b load_err=%b",
                         x.name, x.id, ad, ac, ab, ae, x.d, x.c, x.b, x.e);
            end
        end
    endtask

    // Drive one DUT's inputs for a cycle and expect its registered result.
    task automatic step(input int id, input logic ld, input logic [11:0] lb, input logic up,
                        input logic dn, input logic [11:0] d, input logic c, input logic b,
                        input logic e, input string name);
        case (id)
            0:       begin ld0 = ld; lb0 = lb[7:0]; up0 = up; dn0 = dn; end
            1:       begin ld1 = ld; lb1 = lb[7:0]; up1 = up; dn1 = dn; end
            default: begin ld2 = ld; lb2 = lb;      up2 = up; dn2 = dn; end
        endcase
        push_exp(id, d, c, b, e, name);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        {up0, dn0, ld0, up1, dn1, ld1, up2, dn2, ld2} = '0;
        lb0 = '0; lb1 = '0; lb2 = '0;

        // Reset with en_up held high, then release: no tick on release.
        up0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_exp(0, 12'h000, 0, 0, 0, "rst_dut0");
            push_exp(1, 12'h001, 0, 0, 0, "rst_dut1");
            push_exp(2, 12'h000, 0, 0, 0, "rst_dut2");
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 12'h0, 1, 0, 12'h000, 0, 0, 0, "hold_up_after_rst");
        step(0, 0, 12'h0, 0, 0, 12'h000, 0, 0, 0, "up_low_after_rst");

        // 60 rising edges from 00: 01..59 then wrap with one-cycle carry.
        for (int i = 1; i <= 60; i++) begin
            int v;
            v = SAT ? ((i > 59) ? 59 : i) : (i % 60);
            step(0, 0, 12'h0, 1, 0, {4'h0, bcd8(v)}, (!SAT && i == 60), 0, 0, $sformatf("up_%0d", i));
            step(0, 0, 12'h0, 0, 0, {4'h0, bcd8(v)}, 0, 0, 0, $sformatf("up_%0d_rel", i));
        end

        // Table: loads, validity, cancel, load priority, digit borrow/carry, wrap.
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(1, 8'h3A, 0, 0, 8'h00, 0, 0, 1);
        add(1, 8'h45, 0, 0, 8'h45, 0, 0, 0);
        add(1, 8'h60, 0, 0, 8'h45, 0, 0, 1);
        add(1, 8'h99, 0, 0, 8'h45, 0, 0, 1);
        add(1, 8'h30, 0, 0, 8'h30, 0, 0, 0);
        add(0, 8'h00, 1, 1, 8'h30, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h30, 0, 0, 0);
        add(1, 8'h10, 1, 0, 8'h10, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h10, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h10, 0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h09, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h09, 0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h08, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h08, 0, 0, 0);
        add(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        if (SAT) begin
            add(0, 8'h00, 0, 1, 8'h00, 0, 0, 0);
            add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
            add(0, 8'h00, 1, 0, 8'h01, 0, 0, 0);
            add(0, 8'h00, 0, 0, 8'h01, 0, 0, 0);
        end else begin
            add(0, 8'h00, 0, 1, 8'h59, 0, 1, 0);
            add(0, 8'h00, 0, 0, 8'h59, 0, 0, 0);
            add(0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
            add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        end
        add(1, 8'h19, 0, 0, 8'h19, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h20, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h20, 0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h19, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h19, 0, 0, 0);
        for (int k = 0; k < tbl.size(); k++) begin
            step(0, tbl[k].ld, {4'h0, tbl[k].lb}, tbl[k].up, tbl[k].dn,
                 {4'h0, tbl[k].d}, tbl[k].c, tbl[k].b, tbl[k].e, $sformatf("tbl%0d", k));
        end

        // Range 01..12: down-wrap, out-of-range loads, up-wrap.
        step(1, 0, 12'h0, 0, 1, SAT ? 12'h001 : 12'h012, 0, !SAT, 0, "r12_down_wrap");
        step(1, 0, 12'h0, 0, 0, SAT ? 12'h001 : 12'h012, 0, 0, 0, "r12_down_rel");
        step(1, 1, 12'h013, 0, 0, SAT ? 12'h001 : 12'h012, 0, 0, 1, "r12_load_13");
        step(1, 1, 12'h000, 0, 0, SAT ? 12'h001 : 12'h012, 0, 0, 1, "r12_load_00");
        step(1, 1, 12'h007, 0, 0, 12'h007, 0, 0, 0, "r12_load_07");
        step(1, 1, 12'h012, 0, 0, 12'h012, 0, 0, 0, "r12_load_12");
        step(1, 0, 12'h0, 1, 0, SAT ? 12'h012 : 12'h001, !SAT, 0, 0, "r12_up_wrap");
        step(1, 0, 12'h0, 0, 0, SAT ? 12'h012 : 12'h001, 0, 0, 0, "r12_up_rel");

        // Three digits 000..999: multi-digit carry, full-range wrap, bad nibble.
        step(2, 1, 12'h099, 0, 0, 12'h099, 0, 0, 0, "d3_load_099");
        step(2, 0, 12'h0, 1, 0, 12'h100, 0, 0, 0, "d3_up_099");
        step(2, 0, 12'h0, 0, 0, 12'h100, 0, 0, 0, "d3_up_rel");
        step(2, 1, 12'h999, 0, 0, 12'h999, 0, 0, 0, "d3_load_999");
        step(2, 0, 12'h0, 1, 0, SAT ? 12'h999 : 12'h000, !SAT, 0, 0, "d3_up_999");
        step(2, 0, 12'h0, 0, 0, SAT ? 12'h999 : 12'h000, 0, 0, 0, "d3_up999_rel");
        step(2, 1, 12'h000, 0, 0, 12'h000, 0, 0, 0, "d3_load_000");
        step(2, 0, 12'h0, 0, 1, SAT ? 12'h000 : 12'h999, 0, !SAT, 0, "d3_down_000");
        step(2, 0, 12'h0, 0, 0, SAT ? 12'h000 : 12'h999, 0, 0, 0, "d3_down_rel");
        step(2, 1, 12'h0A0, 0, 0, SAT ? 12'h000 : 12'h999, 0, 0, 1, "d3_load_0A0");
        step(2, 1, 12'h909, 0, 0, 12'h909, 0, 0, 0, "d3_load_909");
        step(2, 0, 12'h0, 1, 0, 12'h910, 0, 0, 0, "d3_up_909");
        step(2, 0, 12'h0, 0, 0, 12'h910, 0, 0, 0, "d3_up909_rel");

        // Reset mid-operation discards ticks and loads.
        step(0, 1, 12'h045, 0, 0, 12'h045, 0, 0, 0, "mid_load_45");
        reset = 1'b1;
        push_exp(1, 12'h001, 0, 0, 0, "mid_rst_dut1");
        step(0, 0, 12'h0, 1, 0, 12'h000, 0, 0, 0, "mid_rst_up");
        step(0, 1, 12'h03A, 1, 0, 12'h000, 0, 0, 0, "mid_rst_badload");
        reset = 1'b0;
        step(0, 0, 12'h0, 1, 0, 12'h000, 0, 0, 0, "mid_rel_up_held");
        step(0, 0, 12'h0, 0, 0, 12'h000, 0, 0, 0, "mid_up_low");
        step(0, 0, 12'h0, 1, 0, 12'h001, 0, 0, 0, "mid_up_again");
        step(0, 0, 12'h0, 0, 0, 12'h001, 0, 0, 0, "mid_up_again_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/contador_bcd_ud_param.md
Name: contador_bcd_ud_param

Overview:
- Parametrised up/down counter held directly in packed BCD, with a programmable range [MIN_VAL..MAX_VAL].
- Generalises the fixed 0-59 two-digit clock-field counter so one block serves seconds, minutes, hours, days and months.
- Adds synchronous BCD preload with validity check, and carry/borrow pulses for cascading fields.
- Sits between the button-debounce logic and the time-register / display-mux path of the clock-setting datapath.

Parameters:
- NDIG, 2, number of BCD digits (legal 1..4).
- MIN_VAL, 0, lowest count value (decimal integer, < MAX_VAL).
- MAX_VAL, 59, highest count value (decimal integer, <= 10^NDIG - 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en_up  in  1  level input; each rising edge increments by one
- en_down  in  1  level input; each rising edge decrements by one
- load  in  1  single-cycle strobe; loads load_bcd
- load_bcd  in  4*NDIG  packed BCD preload value; digit0 in bits [3:0]
- digits  out  4*NDIG  packed BCD count, registered; digit0 = units in bits [3:0]
- carry  out  1  one-cycle pulse on up-wrap MAX_VAL -> MIN_VAL
- borrow  out  1  one-cycle pulse on down-wrap MIN_VAL -> MAX_VAL
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Clock and reset: clk, with reset synchronous, active-high; clock clk. All state updates on the rising edge of clk.
- Reset values: digits = BCD(MIN_VAL); carry, borrow and load_err = 0.
- Edge detect:
  - en_up_q and en_down_q register their inputs every cycle, including during reset, so an input held high across reset release gives no tick.
  - up_tick = en_up & ~en_up_q; down_tick = en_down & ~en_down_q.
- Latency: a tick or load in cycle N is visible on digits, carry, borrow and load_err after edge N (one cycle).
- Priority, highest first: reset > load > (up_tick XOR down_tick) > hold.
  - up_tick and down_tick in the same cycle: no change, no pulses.
- Increment:
  - Per-digit BCD add: a digit at 9 becomes 0 and carries into the next digit.
  - When digits == BCD(MAX_VAL): next value = BCD(MIN_VAL) and carry = 1.
- Decrement:
  - Per-digit BCD subtract: a digit at 0 becomes 9 and borrows from the next digit.
  - When digits == BCD(MIN_VAL): next value = BCD(MAX_VAL) and borrow = 1.
- Hold: count is held with no tick. Out-of-range values are never produced, so no spontaneous wrap occurs.
- Load:
  - Accepted when every nibble of load_bcd is <= 9 and MIN_VAL <= value <= MAX_VAL. Next digits = load_bcd.
  - Otherwise digits is unchanged and load_err = 1 for one cycle.
  - Ticks arriving in the same cycle as a load are discarded (not deferred).
- carry, borrow and load_err are registered, default 0 each cycle, and are mutually exclusive.
- Range comparison: done on BCD digit vectors. Constants BCD(MIN_VAL) and BCD(MAX_VAL) are computed at elaboration. No binary count is kept.
- Reset mid-operation: pending edges are discarded, pulses are cleared, and digits is forced to BCD(MIN_VAL).

Optional Feature:
- Macro: CONTADOR_BCD_SAT_EN.
- Defined: saturating mode.
  - Increment at MAX_VAL holds MAX_VAL; decrement at MIN_VAL holds MIN_VAL.
  - carry and borrow are tied to 0.
  - All other behaviour is unchanged.
- Undefined: wrap mode as described under Behaviour.

Test Plan:
- Reset with en_up held high, then release; hold en_up high for 5 cycles -> digits = 8'h00 and no increment (no tick at reset release).
- Defaults, 60 rising edges of en_up from 00 -> digits steps 01..59 then 00; carry high exactly one cycle on the 59 -> 00 step.
- MIN_VAL=1, MAX_VAL=12, one rising edge of en_down from 01 -> digits = 8'h12 and borrow = 1 for one cycle. Then load_bcd=8'h13 -> load_err = 1 and digits stays 8'h12.
- load_bcd=8'h3A (non-BCD) -> load_err = 1 and digits unchanged. Then load_bcd=8'h45 -> digits = 8'h45 and load_err = 0.
- en_up and en_down rising in the same cycle at 8'h30 -> digits stays 8'h30 with no pulses. Load of 8'h10 coincident with up_tick -> digits = 8'h10.
- NDIG=3, MAX_VAL=999 at 8'h099 (12-bit 0x099), one up -> 12'h100. Build with CONTADOR_BCD_SAT_EN at 999, one up -> stays 12'h999 and carry = 0.
